// File: rtl/ccff_loader_pkg.sv
// Shared types, default sizes and width helper for the configuration-chain loader.
package ccff_loader_pkg;

  localparam int unsigned NumChainsDef = 10;
  localparam int unsigned ChainLenDef  = 4096;
  localparam int unsigned SettleCycDef = 4;
  localparam int unsigned StallMaxDef  = 1024;

  typedef enum logic [2:0] {
    StIdle,
    StLoadLo,
    StLoadHi,
    StSettle,
    StDone,
    StError
  } ccff_state_e;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ccff_stall_timer.sv
// Saturating up-counter with clear and enable. expired_o flags the enabled cycle on
// which the count reaches TERMINAL, so the caller can act on that same edge.
module ccff_stall_timer
  import ccff_loader_pkg::*;
#(
  parameter int unsigned TERMINAL = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = cnt_width(TERMINAL);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and hold at TERMINAL.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntW'(TERMINAL))) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && !clr_i && (cnt_q == CntW'(TERMINAL - 1));

endmodule

// File: rtl/ccff_loader.sv
// Streams a bitstream into the parallel configuration chains, generating prog_clock
// at clk/2 and sequencing config_enable / CFG_DONE. All outputs are registered.
module ccff_loader
  import ccff_loader_pkg::*;
#(
  parameter int unsigned NUM_CHAINS = NumChainsDef,
  parameter int unsigned CHAIN_LEN  = ChainLenDef,
  parameter int unsigned SETTLE_CYC = SettleCycDef,
  parameter int unsigned STALL_MAX  = StallMaxDef
) (
  input  logic                                clk,
  input  logic                                global_reset,
  input  logic                                start,
  input  logic [NUM_CHAINS-1:0]               bs_data,
  input  logic                                bs_valid,
  output logic                                bs_ready,
  output logic [NUM_CHAINS-1:0]               ccff_head,
  output logic                                prog_clock,
  output logic                                config_enable,
  output logic                                CFG_DONE,
  output logic                                busy,
  output logic                                error,
  output logic [cnt_width(CHAIN_LEN)-1:0]     beat_count
);

  localparam int unsigned BcW = cnt_width(CHAIN_LEN);

  ccff_state_e           state_q;
  logic                  bs_ready_q, prog_clock_q, config_enable_q, cfg_done_q;
  logic                  busy_q, error_q;
  logic [NUM_CHAINS-1:0] ccff_head_q;
  logic [BcW-1:0]        beat_count_q;
  logic                  stall_expired, settle_expired;

  // Stall timer only runs on LOAD_LO cycles without a beat; anything else resets it.
  ccff_stall_timer #(
    .TERMINAL (STALL_MAX)
  ) u_stall_timer (
    .clk_i     (clk),
    .rst_ni    (global_reset),
    .clr_i     ((state_q != StLoadLo) || bs_valid),
    .en_i      ((state_q == StLoadLo) && !bs_valid),
    .expired_o (stall_expired)
  );

  ccff_stall_timer #(
    .TERMINAL (SETTLE_CYC)
  ) u_settle_timer (
    .clk_i     (clk),
    .rst_ni    (global_reset),
    .clr_i     (state_q != StSettle),
    .en_i      (state_q == StSettle),
    .expired_o (settle_expired)
  );

  // Load sequencer; every output is updated on the transition that enters its state.
  always_ff @(posedge clk or negedge global_reset) begin
    if (!global_reset) begin
      state_q         <= StIdle;
      bs_ready_q      <= 1'b0;
      prog_clock_q    <= 1'b0;
      config_enable_q <= 1'b0;
      cfg_done_q      <= 1'b0;
      busy_q          <= 1'b0;
      error_q         <= 1'b0;
      ccff_head_q     <= '0;
      beat_count_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone, StError: begin
          if (start) begin
            state_q         <= StLoadLo;
            beat_count_q    <= '0;
            config_enable_q <= 1'b1;
            cfg_done_q      <= 1'b0;
            error_q         <= 1'b0;
            bs_ready_q      <= 1'b1;
            busy_q          <= 1'b1;
          end
        end
        StLoadLo: begin
          // bs_ready is high throughout LOAD_LO, so bs_valid alone is the handshake.
          if (bs_valid) begin
            state_q      <= StLoadHi;
            ccff_head_q  <= bs_data;
            prog_clock_q <= 1'b1;
            bs_ready_q   <= 1'b0;
          end else if (stall_expired) begin
            state_q         <= StError;
            error_q         <= 1'b1;
            config_enable_q <= 1'b0;
            bs_ready_q      <= 1'b0;
            busy_q          <= 1'b0;
          end
        end
        StLoadHi: begin
          prog_clock_q <= 1'b0;
          if (beat_count_q < BcW'(CHAIN_LEN)) begin
            beat_count_q <= beat_count_q + BcW'(1);
          end
          if (beat_count_q == BcW'(CHAIN_LEN - 1)) begin
            state_q         <= StSettle;
            config_enable_q <= 1'b0;
          end else begin
            state_q    <= StLoadLo;
            bs_ready_q <= 1'b1;
          end
        end
        StSettle: begin
          if (settle_expired) begin
            state_q    <= StDone;
            cfg_done_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bs_ready      = bs_ready_q;
  assign prog_clock    = prog_clock_q;
  assign config_enable = config_enable_q;
  assign CFG_DONE      = cfg_done_q;
  assign busy          = busy_q;
  assign error         = error_q;
  assign ccff_head     = ccff_head_q;
  assign beat_count    = beat_count_q;

endmodule
